// File: rtl/demux.sv
// Registered 1-to-NUM_OUTPUT demultiplexer with valid/ready handshaking and one holding register per channel.
// Optional broadcast of a word to every channel is enabled by defining DEMUX_BROADCAST_EN.
module demux #(
  parameter  int NUM_OUTPUT = 4,
  parameter  int BIT_WIDTH  = 8,
  localparam int SEL_W      = (NUM_OUTPUT > 1) ? $clog2(NUM_OUTPUT) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BIT_WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]                select,
  input  logic                            auto_mode,
  input  logic                            ptr_clear,
`ifdef DEMUX_BROADCAST_EN
  input  logic                            in_broadcast,
`endif
  output logic [NUM_OUTPUT-1:0]           out_valid,
  input  logic [NUM_OUTPUT-1:0]           out_ready,
  output logic [NUM_OUTPUT*BIT_WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]                auto_ptr,
  output logic                            drop_pulse
);

  logic [SEL_W-1:0]      auto_ptr_q, auto_ptr_d;
  logic [SEL_W-1:0]      dst;
  logic [NUM_OUTPUT-1:0] out_valid_q, out_valid_d;
  logic [NUM_OUTPUT-1:0] can_load;
  logic [NUM_OUTPUT-1:0] dst_hit;
  logic [NUM_OUTPUT-1:0] load;
  logic                  drop_q, drop_d;
  logic                  bcast;
  logic                  accept;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_broadcast;
`else
  assign bcast = 1'b0;
`endif

  assign dst = auto_mode ? auto_ptr_q : select;

  // An out-of-range select matches no channel, so dst_hit is all-zero for it.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUT; gi++) begin : g_chan
      logic [BIT_WIDTH-1:0] data_q;

      assign can_load[gi]    = ~out_valid_q[gi] | out_ready[gi];
      assign dst_hit[gi]     = (dst == SEL_W'(gi));
      assign load[gi]        = accept & (bcast | dst_hit[gi]);
      assign out_valid_d[gi] = load[gi] | (out_valid_q[gi] & ~out_ready[gi]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else if (load[gi]) begin
          data_q <= in_data;
        end
      end

      assign out_data[gi*BIT_WIDTH +: BIT_WIDTH] = data_q;
    end
  endgenerate

  always_comb begin
    in_ready   = 1'b1;
    accept     = 1'b0;
    drop_d     = 1'b0;
    auto_ptr_d = auto_ptr_q;

    if (bcast) begin
      in_ready = &can_load;
    end else if (|dst_hit) begin
      in_ready = |(dst_hit & can_load);
    end

    accept = in_valid & in_ready;
    drop_d = accept & ~bcast & ~(|dst_hit);

    // Clear wins over advance; the word in the clear cycle already used the old pointer.
    if (ptr_clear) begin
      auto_ptr_d = '0;
    end else if (accept & auto_mode & ~bcast) begin
      if (auto_ptr_q == SEL_W'(NUM_OUTPUT - 1)) begin
        auto_ptr_d = '0;
      end else begin
        auto_ptr_d = auto_ptr_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      auto_ptr_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      auto_ptr_q  <= auto_ptr_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign auto_ptr   = auto_ptr_q;
  assign drop_pulse = drop_q;

endmodule

// File: tb/tb_demux.sv
// Scoreboard bench for demux: a 4-channel instance checked through per-channel expected-data queues,
// plus a 3-channel instance for the out-of-range drop path.
module tb_demux;
  localparam int NA = 4;
  localparam int NB = 3;
  localparam int W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            a_in_valid, a_in_ready, a_auto, a_clear, a_bcast, a_drop;
  logic [W-1:0]    a_in_data;
  logic [1:0]      a_select, a_ptr;
  logic [NA-1:0]   a_out_valid, a_out_ready;
  logic [NA*W-1:0] a_out_data;

  logic            b_in_valid, b_in_ready, b_auto, b_clear, b_bcast, b_drop;
  logic [W-1:0]    b_in_data;
  logic [1:0]      b_select, b_ptr;
  logic [NB-1:0]   b_out_valid, b_out_ready;
  logic [NB*W-1:0] b_out_data;

  demux #(.NUM_OUTPUT(NA), .BIT_WIDTH(W)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .select(a_select), .auto_mode(a_auto), .ptr_clear(a_clear),
`ifdef DEMUX_BROADCAST_EN
    .in_broadcast(a_bcast),
`endif
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .auto_ptr(a_ptr), .drop_pulse(a_drop)
  );

  demux #(.NUM_OUTPUT(NB), .BIT_WIDTH(W)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .select(b_select), .auto_mode(b_auto), .ptr_clear(b_clear),
`ifdef DEMUX_BROADCAST_EN
    .in_broadcast(b_bcast),
`endif
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .auto_ptr(b_ptr), .drop_pulse(b_drop)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] sb_q [NA][$];
  int mptr = 0;

  // Output side: every completed handshake is compared against the oldest expected word of that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_drop_idle", a_drop, 1'b0);
      for (int i = 0; i < NA; i++) begin
        if (a_out_valid[i] && a_out_ready[i]) begin
          check($sformatf("ch%0d_pending", i), (sb_q[i].size() > 0), 1'b1);
          if (sb_q[i].size() > 0)
            check($sformatf("ch%0d_data", i), a_out_data[i*W +: W], sb_q[i].pop_front());
        end
      end
    end
  end

  // Input side: one clock; the accepted word is pushed to the queue of the channel the model predicts.
  task automatic tick();
    int dst;
    @(negedge clk);
    dst = a_auto ? mptr : int'(a_select);
    if (a_in_valid && a_in_ready) begin
      if (a_bcast) begin
        for (int i = 0; i < NA; i++) sb_q[i].push_back(a_in_data);
      end else if (dst < NA) begin
        sb_q[dst].push_back(a_in_data);
      end
      if (a_clear) mptr = 0;
      else if (a_auto && !a_bcast) mptr = (mptr + 1) % NA;
    end else if (a_clear) begin
      mptr = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] d, input logic [1:0] s);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_select   = s;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    a_in_valid = 0; a_in_data = '0; a_select = '0; a_auto = 0; a_clear = 0; a_bcast = 0; a_out_ready = '0;
    b_in_valid = 0; b_in_data = '0; b_select = '0; b_auto = 0; b_clear = 0; b_bcast = 0; b_out_ready = '0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", a_out_valid, 4'h0);
    check("rst_data", a_out_data, 32'h0);
    check("rst_ptr", a_ptr, 2'd0);
    check("rst_drop", a_drop, 1'b0);
    check("rst_ready", a_in_ready, 1'b1);
    check("rst_b_valid", b_out_valid, 3'b000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill all four channels with consumers stalled.
    for (int i = 0; i < NA; i++) put(8'(17 * (i + 1)), 2'(i));
    a_in_valid = 1'b0;
    check("fill_valid", a_out_valid, 4'hF);
    check("fill_data", a_out_data, 32'h44332211);
    a_in_valid = 1'b1; a_select = 2'd2; a_in_data = 8'h99;
    #1 check("full_ready", a_in_ready, 1'b0);
    tick();

    // Pass-through on a full channel: one word per cycle.
    a_out_ready = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      a_in_valid = 1'b1; a_select = 2'd2; a_in_data = 8'(8'hA0 + k);
      #1;
      check("stream_ready", a_in_ready, 1'b1);
      check("stream_valid", a_out_valid[2], 1'b1);
      tick();
    end
    a_in_valid = 1'b0;
    tick();
    a_out_ready = 4'hF;
    tick();
    tick();

    // Round-robin destination, then clear concurrent with an accept.
    a_auto = 1'b1;
    for (int k = 0; k < 6; k++) put(8'(8'hB0 + k), 2'd0);
    check("auto_ptr6", a_ptr, 2'd2);
    a_clear = 1'b1;
    put(8'hCC, 2'd0);
    a_clear = 1'b0; a_in_valid = 1'b0;
    check("clear_ptr", a_ptr, 2'd0);
    tick();

    // Asynchronous reset between clock edges.
    a_out_ready = 4'h0;
    put(8'h01, 2'd0);
    put(8'h02, 2'd0);
    a_in_valid = 1'b0;
    check("pre_rst_valid", a_out_valid, 4'b0011);
    check("pre_rst_ptr", a_ptr, 2'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", a_out_valid, 4'h0);
    check("async_data", a_out_data, 32'h0);
    check("async_ptr", a_ptr, 2'd0);
    check("async_ready", a_in_ready, 1'b1);
    for (int i = 0; i < NA; i++) sb_q[i].delete();
    mptr = 0;
    #1 rst_n = 1'b1;

`ifdef DEMUX_BROADCAST_EN
    a_auto = 1'b1; a_out_ready = 4'b0001;
    put(8'h66, 2'd0);
    put(8'h77, 2'd0);
    a_bcast = 1'b1; a_in_valid = 1'b1; a_in_data = 8'hC3;
    #1 check("bcast_blocked", a_in_ready, 1'b0);
    tick();
    a_out_ready = 4'b0010;
    #1 check("bcast_ready", a_in_ready, 1'b1);
    tick();
    a_in_valid = 1'b0; a_bcast = 1'b0; a_out_ready = 4'h0;
    #1;
    check("bcast_valid", a_out_valid, 4'hF);
    check("bcast_data", a_out_data, 32'hC3C3C3C3);
    check("bcast_ptr", a_ptr, 2'd2);
    a_out_ready = 4'hF;
    tick();
`endif

    // Three-channel instance: select=3 is out of range and is dropped.
    b_in_valid = 1'b1; b_select = 2'd0; b_in_data = 8'h10;
    tick();
    b_select = 2'd3; b_in_data = 8'h5A;
    #1;
    check("b_oor_ready", b_in_ready, 1'b1);
    check("b_valid_pre", b_out_valid, 3'b001);
    tick();
    b_in_valid = 1'b0;
    check("b_drop", b_drop, 1'b1);
    check("b_valid_post", b_out_valid, 3'b001);
    check("b_ch0_data", b_out_data[7:0], 8'h10);
    tick();
    check("b_drop_end", b_drop, 1'b0);

    a_out_ready = 4'hF;
    tick();
    tick();
    for (int i = 0; i < NA; i++) check($sformatf("ch%0d_left", i), sb_q[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
